axis_reg_array_skid: RTL and testbench

Parametrised successor to the fixed AXI4S register-slice chain. Configurable data width, depth and per-chain slice mode, with beat-occupancy tracking and a synchronous flush. Sits on AXI4S paths between user logic and shell crossbars, where timing closure and drain/flush control are both needed.

---
 rtl/axis_reg_array_skid.sv | 144 ++++++++++++++
 tb/tb_axis_reg_array_skid.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_reg_array_skid.sv
// axis_reg_array_skid: parametrised AXI4-Stream register-slice chain with occupancy, flush; optional counters via AXIS_REG_ARRAY_STATS_EN
module axis_reg_array_skid #(
  parameter int DATA_BITS = 512,
  parameter int N_STAGES = 2,
  parameter int REG_MODE = 0,
  parameter int OCC_BITS = (N_STAGES == 0) ? 1 : $clog2(2 * N_STAGES + 1)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   flush,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [OCC_BITS-1:0]    occupancy,
  output logic                   idle
`ifdef AXIS_REG_ARRAY_STATS_EN
  ,
  output logic [31:0]            stat_beats,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_stall
`endif
);
  localparam int KB = DATA_BITS / 8;
  localparam int PW = DATA_BITS + KB + 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} slice_state_t;
  logic s_fire, m_fire;
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
  generate
    if (N_STAGES == 0) begin : g_pass
      assign s_axis_tready = m_axis_tready;
      assign m_axis_tvalid = s_axis_tvalid;
      assign m_axis_tdata = s_axis_tdata;
      assign m_axis_tkeep = s_axis_tkeep;
      assign m_axis_tlast = s_axis_tlast;
      assign occupancy = '0;
      assign idle = 1'b1;
    end else begin : g_chain
      logic [N_STAGES:0] vld;
      logic [PW-1:0] pl [N_STAGES+1];
      logic [OCC_BITS-1:0] occ;
      // Beats offered during flush or reset never enter the chain
      assign vld[0] = s_axis_tvalid && !flush && !areset;
      assign pl[0] = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      assign m_axis_tvalid = vld[N_STAGES];
      assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pl[N_STAGES];
      for (genvar i = 0; i < N_STAGES; i++) begin : g_slice
        logic up_r, dn_r;
        if (i == N_STAGES - 1) begin : g_last
          assign dn_r = m_axis_tready;
        end else begin : g_mid
          assign dn_r = g_slice[i+1].up_r;
        end
        if (REG_MODE == 0) begin : g_skid
          slice_state_t st, st_nx;
          logic rdy_q, acc, out;
          logic [PW-1:0] main_q, skid_q;
          assign acc = vld[i] && rdy_q;
          assign out = (st != EMPTY) && dn_r;
          assign up_r = rdy_q;
          assign vld[i+1] = st != EMPTY;
          assign pl[i+1] = main_q;
          // Next state: flush empties the slice, otherwise fill/drain by accept and output
          always_comb begin
            st_nx = flush ? EMPTY :
                    (st == EMPTY) ? (acc ? ONE : EMPTY) :
                    (st == ONE) ? ((acc && !out) ? TWO : (!acc && out) ? EMPTY : ONE) :
                    (out ? ONE : TWO);
          end
          // State and registered ready; ready drops only while both entries are full
          always_ff @(posedge aclk) begin
            if (areset) begin
              st <= EMPTY;
              rdy_q <= 1'b1;
            end else begin
              st <= st_nx;
              rdy_q <= st_nx != TWO;
            end
          end
          // Payload: main feeds the output, skid catches the beat accepted while stalled
          always_ff @(posedge aclk) begin
            if (acc && (st == EMPTY || (st == ONE && out)))
              main_q <= pl[i];
            else if (st == TWO && out)
              main_q <= skid_q;
            if (acc && st == ONE && !out)
              skid_q <= pl[i];
          end
        end else begin : g_fwd
          logic v_q;
          logic [PW-1:0] d_q;
          assign up_r = !v_q || dn_r;
          assign vld[i+1] = v_q;
          assign pl[i+1] = d_q;
          // Single-entry valid: load on accept, clear when drained or flushed
          always_ff @(posedge aclk) begin
            if (areset || flush)
              v_q <= 1'b0;
            else if (vld[i] && up_r)
              v_q <= 1'b1;
            else if (dn_r)
              v_q <= 1'b0;
          end
          // Payload captured on accept only
          always_ff @(posedge aclk) begin
            if (vld[i] && up_r)
              d_q <= pl[i];
          end
        end
      end
      assign s_axis_tready = g_slice[0].up_r && !flush && !areset;
      // Beat count held in the chain
      always_ff @(posedge aclk) begin
        if (areset || flush)
          occ <= '0;
        else
          occ <= occ + OCC_BITS'(s_fire) - OCC_BITS'(m_fire);
      end
      assign occupancy = occ;
      assign idle = occ == '0;
    end
  endgenerate
`ifdef AXIS_REG_ARRAY_STATS_EN
  // Traffic counters; survive flush, wrap naturally
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_beats <= '0;
      stat_pkts <= '0;
      stat_stall <= '0;
    end else begin
      stat_beats <= stat_beats + 32'(m_fire);
      stat_pkts <= stat_pkts + 32'(m_fire && m_axis_tlast);
      stat_stall <= stat_stall + 32'(m_axis_tvalid && !m_axis_tready);
    end
  end
`endif
endmodule

// File: tb/tb_axis_reg_array_skid.sv
// tb_axis_reg_array_skid: directed vectors and sequences for skid and forward chains
module tb_axis_reg_array_skid;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic flush = 1'b0;
  logic sv = 1'b0;
  logic mr = 1'b1;
  logic [15:0] sd = '0;
  logic [1:0] sk = '0;
  logic sl = 1'b0;
  logic sr0, mv0, ml0, idle0, sr1, mv1, ml1, idle1;
  logic [15:0] md0, md1;
  logic [1:0] mk0, mk1;
  logic [2:0] occ0, occ1;
`ifdef AXIS_REG_ARRAY_STATS_EN
  logic [31:0] sb0, sp0, ss0, sb1, sp1, ss1;
`endif
  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic fl; logic sv; logic [15:0] d; logic l; logic mr;
    logic e_sr; logic e_mv; logic [15:0] e_md; logic e_ml; logic [2:0] e_occ;
  } vec_t;
  vec_t vt [11];

  always #5 aclk = ~aclk;

  axis_reg_array_skid #(.DATA_BITS(16), .N_STAGES(2), .REG_MODE(0)) dut0 (
    .aclk(aclk), .areset(areset), .flush(flush),
    .s_axis_tvalid(sv), .s_axis_tready(sr0), .s_axis_tdata(sd), .s_axis_tkeep(sk), .s_axis_tlast(sl),
    .m_axis_tvalid(mv0), .m_axis_tready(mr), .m_axis_tdata(md0), .m_axis_tkeep(mk0), .m_axis_tlast(ml0),
    .occupancy(occ0), .idle(idle0)
`ifdef AXIS_REG_ARRAY_STATS_EN
    , .stat_beats(sb0), .stat_pkts(sp0), .stat_stall(ss0)
`endif
  );

  axis_reg_array_skid #(.DATA_BITS(16), .N_STAGES(2), .REG_MODE(1)) dut1 (
    .aclk(aclk), .areset(areset), .flush(flush),
    .s_axis_tvalid(sv), .s_axis_tready(sr1), .s_axis_tdata(sd), .s_axis_tkeep(sk), .s_axis_tlast(sl),
    .m_axis_tvalid(mv1), .m_axis_tready(mr), .m_axis_tdata(md1), .m_axis_tkeep(mk1), .m_axis_tlast(ml1),
    .occupancy(occ1), .idle(idle1)
`ifdef AXIS_REG_ARRAY_STATS_EN
    , .stat_beats(sb1), .stat_pkts(sp1), .stat_stall(ss1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1; flush = 1'b0; sv = 1'b0; mr = 1'b1;
    #1 chk("rst_s_ready_low", 32'(sr0), 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_m_valid", 32'(mv0), 0);
    chk("rst_occ", 32'(occ0), 0);
    chk("rst_idle", 32'(idle0), 1);
    chk("rst_s_ready_after", 32'(sr0), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, got0, got1, sent, rcvd, npkts, nstall;
    logic fire;
    vt = '{
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0},
      '{1'b0, 1'b1, 16'h00a1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0},
      '{1'b0, 1'b1, 16'h00a2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1},
      '{1'b0, 1'b1, 16'h00a3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00a1, 1'b0, 3'd2},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00a1, 1'b0, 3'd3},
      '{1'b1, 1'b1, 16'h00a4, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00a1, 1'b0, 3'd3},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0},
      '{1'b0, 1'b1, 16'h00b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00b1, 1'b1, 3'd1},
      '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0}
    };
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge aclk);
      flush = vt[i].fl; sv = vt[i].sv; sd = vt[i].d; sk = 2'b11; sl = vt[i].l; mr = vt[i].mr;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(sr0), 32'(vt[i].e_sr));
      chk($sformatf("vec%0d_m_valid", i), 32'(mv0), 32'(vt[i].e_mv));
      chk($sformatf("vec%0d_occ", i), 32'(occ0), 32'(vt[i].e_occ));
      chk($sformatf("vec%0d_idle", i), 32'(idle0), 32'(vt[i].e_occ == 3'd0));
      if (vt[i].e_mv) begin
        chk($sformatf("vec%0d_data", i), 32'(md0), 32'(vt[i].e_md));
        chk($sformatf("vec%0d_last", i), 32'(ml0), 32'(vt[i].e_ml));
        chk($sformatf("vec%0d_keep", i), 32'(mk0), 32'h3);
      end
    end
    flush = 1'b0;

    do_reset();
    for (int c = 0; c < 104; c++) begin
      @(negedge aclk);
      sv = c < 100; sd = 16'(c); sk = sd[1:0]; sl = (c % 10) == 9; mr = 1'b1;
      #1;
      if (c < 100) chk("stream_s_ready", 32'(sr0), 1);
      chk($sformatf("stream_m_valid_c%0d", c), 32'(mv0), 32'(c >= 2 && c < 102));
      if (c >= 2 && c < 102) begin
        chk("stream_data", 32'(md0), 32'(c - 2));
        chk("stream_keep", 32'(mk0), 32'((c - 2) & 3));
        chk("stream_last", 32'(ml0), 32'(((c - 2) % 10) == 9));
      end
    end

    do_reset();
    acc0 = 0; acc1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      sv = 1'b1; mr = 1'b0; sd = 16'(acc0); sk = 2'b11; sl = 1'b0;
      #1;
      if (sr0) acc0++;
      if (sr1) acc1++;
    end
    @(negedge aclk);
    sv = 1'b0;
    #1;
    chk("bp_acc_skid", 32'(acc0), 4);
    chk("bp_acc_fwd", 32'(acc1), 2);
    chk("bp_s_ready_skid", 32'(sr0), 0);
    chk("bp_s_ready_fwd", 32'(sr1), 0);
    chk("bp_occ_skid", 32'(occ0), 4);
    chk("bp_occ_fwd", 32'(occ1), 2);
    mr = 1'b1;
    #1;
    chk("bp_fwd_ready_follows_hi", 32'(sr1), 1);
    chk("bp_skid_ready_registered", 32'(sr0), 0);
    mr = 1'b0;
    #1;
    chk("bp_fwd_ready_follows_lo", 32'(sr1), 0);
    got0 = 0; got1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      mr = 1'b1;
      #1;
      if (mv0) begin
        chk("bp_drain_skid_data", 32'(md0), 32'(got0));
        got0++;
      end
      if (mv1) begin
        chk("bp_drain_fwd_data", 32'(md1), 32'(got1));
        got1++;
      end
    end
    @(negedge aclk);
    #1;
    chk("bp_drained_skid", 32'(got0), 4);
    chk("bp_drained_fwd", 32'(got1), 2);
    chk("bp_occ_skid_end", 32'(occ0), 0);
    chk("bp_idle_skid_end", 32'(idle0), 1);
    chk("bp_occ_fwd_end", 32'(occ1), 0);

    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      sv = 1'b1; sd = 16'(c); mr = 1'b0;
    end
    @(negedge aclk);
    areset = 1'b1;
    #1 chk("mid_rst_s_ready", 32'(sr0), 0);
    @(negedge aclk);
    areset = 1'b0; sv = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(mv0), 0);
    chk("mid_rst_occ", 32'(occ0), 0);
    chk("mid_rst_idle", 32'(idle0), 1);
    chk("mid_rst_s_ready", 32'(sr0), 1);

    do_reset();
    sent = 0; rcvd = 0; npkts = 0; nstall = 0; fire = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge aclk);
      if (fire || !sv) sv = 1'($urandom_range(0, 1));
      sd = 16'(sent); sk = sd[1:0]; sl = (sent % 3) == 2;
      mr = 1'($urandom_range(0, 1));
      #1;
      fire = sv && sr0;
      if (fire) sent++;
      if (mv0 && mr) begin
        chk("rand_data", 32'(md0), 32'(rcvd & 16'hffff));
        chk("rand_last", 32'(ml0), 32'((rcvd % 3) == 2));
        if ((rcvd % 3) == 2) npkts++;
        rcvd++;
      end
      if (mv0 && !mr) nstall++;
    end
    @(negedge aclk);
    sv = 1'b0; mr = 1'b0;
    #1;
    chk("rand_occ", 32'(occ0), 32'(sent - rcvd));
    chk("rand_progress", 32'(rcvd > 100), 1);
`ifdef AXIS_REG_ARRAY_STATS_EN
    chk("stat_beats", sb0, 32'(rcvd));
    chk("stat_pkts", sp0, 32'(npkts));
    chk("stat_stall", ss0, 32'(nstall));
    do_reset();
    chk("stat_beats_rst", sb0, 0);
    chk("stat_pkts_rst", sp0, 0);
    chk("stat_stall_rst", ss0, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
